// File: rtl/agnus_dma_arbiter.sv
// ---------------------------------------------------------------------------
// agnus_dma_arbiter
//
// Table-driven fixed-priority arbiter for the Agnus chip-bus slot. Each of
// the NCH DMA channels presents a request; the lowest eligible index wins the
// slot. When no channel wins, the CPU gets the slot.
//
// Channel eligibility depends on three things:
//   - a per-channel odd-slot restriction (ODD_ONLY);
//   - a CPU-starvation throttle (THROTTLE, bypassed by nasty);
//   - burst locking with a bounded hold (hold, LOCK_MAX), which only NOLOCK
//     channels may pre-empt.
//
// Ports
//   clk              master clock
//   _reset           asynchronous active-low reset
//   clk7_en          bus-cycle enable, all state advances only when high
//   cck              colour clock phase (1 = odd/chipset slot)
//   req/ena          per-channel DMA request / DMACON enable
//   hold             per-channel burst-lock request
//   nasty            per-channel throttle bypass
//   we_in            per-channel write flag
//   addr_in          flattened chip addresses, channel i at [i*AW +: AW]
//   reg_in           flattened register addresses, channel i at [i*RW +: RW]
//   cpu_req          CPU wants a chip/custom cycle
//   cpu_reg_address  CPU register address (all-ones when idle)
//   grant            one-hot combinational grant for this cycle
//   ack_d            grant delayed by one clk7_en cycle (data phase)
//   dbr/dbwe         Agnus owns the bus / winner write flag
//   cpu_custom       CPU owns the bus
//   address_out      winner chip address (0 when the CPU owns the slot)
//   reg_address_out  winner register address (cpu_reg_address otherwise)
//   starve_cnt       current CPU starvation count
//   lock_act         a burst lock is active
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module agnus_dma_arbiter #(
  parameter int             NCH        = 8,
  parameter int             AW         = 20,
  parameter int             RW         = 8,
  parameter logic [NCH-1:0] ODD_ONLY   = 8'h3F,
  parameter logic [NCH-1:0] THROTTLE   = 8'h80,
  parameter logic [NCH-1:0] NOLOCK     = 8'h03,
  parameter int             STARVE_MAX = 3,
  parameter int             LOCK_MAX   = 4
) (
  input  logic              clk,
  input  logic              _reset,
  input  logic              clk7_en,
  input  logic              cck,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    ena,
  input  logic [NCH-1:0]    hold,
  input  logic [NCH-1:0]    nasty,
  input  logic [NCH-1:0]    we_in,
  input  logic [NCH*AW-1:0] addr_in,
  input  logic [NCH*RW-1:0] reg_in,
  input  logic              cpu_req,
  input  logic [RW-1:0]     cpu_reg_address,
  output logic [NCH-1:0]    grant,
  output logic [NCH-1:0]    ack_d,
  output logic              dbr,
  output logic              dbwe,
  output logic              cpu_custom,
  output logic [AW-1:0]     address_out,
  output logic [RW-1:0]     reg_address_out,
  output logic [1:0]        starve_cnt,
  output logic              lock_act
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = 4;

  // Registered state
  logic           r_run;
  logic [1:0]     r_starve_cnt;
  logic           r_lock_act;
  logic [IW-1:0]  r_lock_owner;
  logic [CW-1:0]  r_lock_cnt;
  logic           r_blk_vld;
  logic [IW-1:0]  r_blk_idx;
  logic [NCH-1:0] r_ack_d;

  // Combinational arbitration
  logic           w_starved;
  logic [NCH-1:0] w_elig;
  logic           w_pri_vld;
  logic [IW-1:0]  w_pri_idx;
  logic           w_nl_vld;
  logic [IW-1:0]  w_nl_idx;
  logic           w_win_vld;
  logic [IW-1:0]  w_win_idx;

  // Next-state values
  logic [1:0]     w_starve_nxt;
  logic           w_lock_act_nxt;
  logic [IW-1:0]  w_lock_owner_nxt;
  logic [CW-1:0]  w_lock_cnt_nxt;
  logic           w_blk_vld_nxt;
  logic [IW-1:0]  w_blk_idx_nxt;
  logic           w_owner_hold;
  logic           w_owner_wins;
  logic [CW-1:0]  w_cnt_inc;
  logic           w_rel_max;
  logic           w_rel_drop;
  logic           w_blocked;

  assign w_starved = (r_starve_cnt == 2'(STARVE_MAX));

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NCH; i++) begin
      w_elig[i] = req[i] & ena[i] & (~ODD_ONLY[i] | cck) &
                  ~(THROTTLE[i] & ~nasty[i] & w_starved);
    end
  end

  // Lowest eligible index overall and lowest eligible NOLOCK index; scanning
  // downwards leaves the lowest match in place.
  always_comb begin
    w_pri_vld = 1'b0;
    w_pri_idx = '0;
    w_nl_vld  = 1'b0;
    w_nl_idx  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_pri_vld = 1'b1;
        w_pri_idx = IW'(i);
      end
      if (w_elig[i] && NOLOCK[i]) begin
        w_nl_vld = 1'b1;
        w_nl_idx = IW'(i);
      end
    end
  end

  // r_run keeps the grant at zero during reset and until the first
  // clk7_en cycle after reset is released.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    if (r_run) begin
      if (!r_lock_act) begin
        w_win_vld = w_pri_vld;
        w_win_idx = w_pri_idx;
      end else if (w_nl_vld) begin
        w_win_vld = 1'b1;
        w_win_idx = w_nl_idx;
      end else if (w_elig[r_lock_owner]) begin
        w_win_vld = 1'b1;
        w_win_idx = r_lock_owner;
      end
    end
  end

  always_comb begin
    grant           = '0;
    dbr             = 1'b0;
    dbwe            = 1'b0;
    cpu_custom      = 1'b1;
    address_out     = '0;
    reg_address_out = cpu_reg_address;
    if (w_win_vld) begin
      grant[w_win_idx] = 1'b1;
      dbr              = 1'b1;
      dbwe             = we_in[w_win_idx];
      cpu_custom       = 1'b0;
      address_out      = addr_in[w_win_idx*AW +: AW];
      reg_address_out  = reg_in[w_win_idx*RW +: RW];
    end
  end

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (!cpu_req || !w_win_vld) begin
      w_starve_nxt = '0;
    end else if (!w_starved) begin
      w_starve_nxt = r_starve_cnt + 2'd1;
    end
  end

  // Lock bookkeeping. A release is resolved before a new lock is considered,
  // so the winner of a releasing cycle may lock at once. The exception is the
  // owner that just hit LOCK_MAX: r_blk_* stops it re-locking on the
  // following cycle.
  always_comb begin
    w_owner_hold     = hold[r_lock_owner] & req[r_lock_owner];
    w_owner_wins     = r_lock_act & w_win_vld & (w_win_idx == r_lock_owner);
    w_cnt_inc        = r_lock_cnt + CW'(1);
    w_rel_max        = w_owner_wins & w_owner_hold & (int'(w_cnt_inc) >= LOCK_MAX);
    w_rel_drop       = r_lock_act & ~w_owner_hold;
    w_blocked        = (r_blk_vld & (w_win_idx == r_blk_idx)) | w_rel_max;
    w_lock_act_nxt   = r_lock_act;
    w_lock_owner_nxt = r_lock_owner;
    w_lock_cnt_nxt   = r_lock_cnt;
    w_blk_vld_nxt    = 1'b0;
    w_blk_idx_nxt    = r_blk_idx;
    if (r_lock_act && !w_rel_max && !w_rel_drop) begin
      // A cycle lost to a NOLOCK channel leaves the count untouched.
      if (w_owner_wins) begin
        w_lock_cnt_nxt = w_cnt_inc;
      end
    end else begin
      w_lock_act_nxt = 1'b0;
      w_lock_cnt_nxt = '0;
      if (w_rel_max) begin
        w_blk_vld_nxt = 1'b1;
        w_blk_idx_nxt = r_lock_owner;
      end
      if (w_win_vld && hold[w_win_idx] && !w_blocked) begin
        w_lock_owner_nxt = w_win_idx;
        w_lock_cnt_nxt   = CW'(1);
        if (LOCK_MAX > 1) begin
          w_lock_act_nxt = 1'b1;
        end else begin
          // A single-grant limit expires on the locking grant itself.
          w_lock_cnt_nxt = '0;
          w_blk_vld_nxt  = 1'b1;
          w_blk_idx_nxt  = w_win_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      r_run        <= 1'b0;
      r_starve_cnt <= '0;
      r_lock_act   <= 1'b0;
      r_lock_owner <= '0;
      r_lock_cnt   <= '0;
      r_blk_vld    <= 1'b0;
      r_blk_idx    <= '0;
      r_ack_d      <= '0;
    end else if (clk7_en) begin
      r_run        <= 1'b1;
      r_starve_cnt <= w_starve_nxt;
      r_lock_act   <= w_lock_act_nxt;
      r_lock_owner <= w_lock_owner_nxt;
      r_lock_cnt   <= w_lock_cnt_nxt;
      r_blk_vld    <= w_blk_vld_nxt;
      r_blk_idx    <= w_blk_idx_nxt;
      r_ack_d      <= grant;
    end
  end

  assign ack_d      = r_ack_d;
  assign starve_cnt = r_starve_cnt;
  assign lock_act   = r_lock_act;

endmodule

// File: tb/tb_agnus_dma_arbiter.sv
// ---------------------------------------------------------------------------
// tb_agnus_dma_arbiter
//
// Directed scoreboard bench for agnus_dma_arbiter.
//
// Stimulus side:
//   - Each vector is driven just after a rising edge.
//   - Its hand-computed grant, starvation count and lock state are queued
//     together with the derived bus outputs.
//
// Monitor side:
//   - A separate monitor pops one entry per falling edge.
//   - It compares the entry against the DUT outputs.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_agnus_dma_arbiter;

  localparam int NCH = 8;
  localparam int AW  = 20;
  localparam int RW  = 8;

  typedef struct packed {
    logic [NCH-1:0] grant;
    logic [NCH-1:0] ackD;
    logic [1:0]     starve;
    logic           lockAct;
    logic           cpuCustom;
    logic           dbr;
    logic           dbwe;
    logic [AW-1:0]  addr;
    logic [RW-1:0]  regAddr;
  } expT;

  logic              clk = 1'b0;
  logic              rstN;
  logic              clk7En;
  logic              cck;
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    ena;
  logic [NCH-1:0]    hold;
  logic [NCH-1:0]    nasty;
  logic [NCH-1:0]    weVec;
  logic [NCH*AW-1:0] addrFlat;
  logic [NCH*RW-1:0] regFlat;
  logic              cpuReq;
  logic [RW-1:0]     cpuRegAddr;
  logic [NCH-1:0]    grant;
  logic [NCH-1:0]    ackD;
  logic              dbr;
  logic              dbwe;
  logic              cpuCustom;
  logic [AW-1:0]     addressOut;
  logic [RW-1:0]     regAddressOut;
  logic [1:0]        starveCnt;
  logic              lockAct;

  logic [AW-1:0]     chanAddr [NCH];
  logic [RW-1:0]     chanReg  [NCH];
  logic [NCH-1:0]    lastEnGrant;
  expT               expQ [$];
  string             nameQ [$];
  int                compared   = 0;
  int                mismatched = 0;

  agnus_dma_arbiter dut (
    .clk             (clk),
    ._reset          (rstN),
    .clk7_en         (clk7En),
    .cck             (cck),
    .req             (req),
    .ena             (ena),
    .hold            (hold),
    .nasty           (nasty),
    .we_in           (weVec),
    .addr_in         (addrFlat),
    .reg_in          (regFlat),
    .cpu_req         (cpuReq),
    .cpu_reg_address (cpuRegAddr),
    .grant           (grant),
    .ack_d           (ackD),
    .dbr             (dbr),
    .dbwe            (dbwe),
    .cpu_custom      (cpuCustom),
    .address_out     (addressOut),
    .reg_address_out (regAddressOut),
    .starve_cnt      (starveCnt),
    .lock_act        (lockAct)
  );

  // 10 ns master clock
  always #5 clk = ~clk;

  // Drive one vector and queue what the DUT must show for it. The data-phase
  // ack is the grant of the most recent enabled cycle, or 0 while in reset.
  task automatic applyStimulus(input string name, input logic rst, input logic en,
                               input logic ck, input logic [NCH-1:0] rq,
                               input logic [NCH-1:0] hd, input logic [NCH-1:0] ns,
                               input logic cr, input logic [NCH-1:0] eGrant,
                               input logic [1:0] eStarve, input logic eLock);
    expT e;
    int  w;
    @(posedge clk);
    #1;
    rstN   = rst;
    clk7En = en;
    cck    = ck;
    req    = rq;
    hold   = hd;
    nasty  = ns;
    cpuReq = cr;
    w = -1;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (eGrant[i]) w = i;
    end
    e.grant     = eGrant;
    e.ackD      = rst ? lastEnGrant : '0;
    e.starve    = eStarve;
    e.lockAct   = eLock;
    e.cpuCustom = (w < 0);
    e.dbr       = (w >= 0);
    e.dbwe      = |(eGrant & weVec);
    e.addr      = (w < 0) ? '0 : chanAddr[w];
    e.regAddr   = (w < 0) ? cpuRegAddr : chanReg[w];
    if (en) lastEnGrant = eGrant;
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  task automatic cmpField(input string tag, input string field,
                          input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s.%s: got %0h expected %0h", tag, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input expT e);
    cmpField(tag, "grant",      32'(grant),         32'(e.grant));
    cmpField(tag, "ack_d",      32'(ackD),          32'(e.ackD));
    cmpField(tag, "starve_cnt", 32'(starveCnt),     32'(e.starve));
    cmpField(tag, "lock_act",   32'(lockAct),       32'(e.lockAct));
    cmpField(tag, "cpu_custom", 32'(cpuCustom),     32'(e.cpuCustom));
    cmpField(tag, "dbr",        32'(dbr),           32'(e.dbr));
    cmpField(tag, "dbwe",       32'(dbwe),          32'(e.dbwe));
    cmpField(tag, "address",    32'(addressOut),    32'(e.addr));
    cmpField(tag, "reg_addr",   32'(regAddressOut), 32'(e.regAddr));
  endtask

  // Monitor: one queued expectation per falling edge, away from the active edge
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      checkOutput(nameQ.pop_front(), expQ.pop_front());
    end
  end

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN        = 1'b0;
    clk7En      = 1'b1;
    cck         = 1'b0;
    req         = '0;
    ena         = 8'hFF;
    hold        = '0;
    nasty       = '0;
    weVec       = 8'h55;
    cpuReq      = 1'b0;
    cpuRegAddr  = 8'hFE;
    lastEnGrant = '0;
    for (int i = 0; i < NCH; i++) begin
      chanAddr[i] = AW'(32'h0_1230 + 32'h1_0000 * i);
      chanReg[i]  = RW'(8'h40 + 2 * i);
      addrFlat[i*AW +: AW] = chanAddr[i];
      regFlat[i*RW +: RW]  = chanReg[i];
    end

    //             name          rst  en   cck  req    hold   nasty cpu  grant  stv  lock
    // Reset and release
    applyStimulus("rst_hold",    0,   1,   1,   8'hFF, 8'h00, 8'h00, 1,  8'h00, 0,   0);
    applyStimulus("rst_rel",     1,   1,   1,   8'h00, 8'h00, 8'h00, 0,  8'h00, 0,   0);
    // Priority and data phase
    applyStimulus("prio_odd",    1,   1,   1,   8'hFF, 8'h00, 8'h00, 0,  8'h01, 0,   0);
    applyStimulus("idle_a",      1,   1,   1,   8'h00, 8'h00, 8'h00, 0,  8'h00, 0,   0);
    applyStimulus("prio_even",   1,   1,   0,   8'hFF, 8'h00, 8'h00, 0,  8'h40, 0,   0);
    applyStimulus("prio_ch3",    1,   1,   1,   8'h38, 8'h00, 8'h00, 0,  8'h08, 0,   0);
    // clk7_en low: grant follows inputs, ack_d holds
    applyStimulus("en_low1",     1,   0,   1,   8'h02, 8'h00, 8'h00, 0,  8'h02, 0,   0);
    applyStimulus("en_low2",     1,   0,   1,   8'h04, 8'h00, 8'h00, 0,  8'h04, 0,   0);
    applyStimulus("en_back",     1,   1,   1,   8'h10, 8'h00, 8'h00, 0,  8'h10, 0,   0);
    applyStimulus("idle_b",      1,   1,   1,   8'h00, 8'h00, 8'h00, 0,  8'h00, 0,   0);
    // Throttle on channel 7
    applyStimulus("thr1",        1,   1,   0,   8'h80, 8'h00, 8'h00, 1,  8'h80, 0,   0);
    applyStimulus("thr2",        1,   1,   0,   8'h80, 8'h00, 8'h00, 1,  8'h80, 1,   0);
    applyStimulus("thr3",        1,   1,   0,   8'h80, 8'h00, 8'h00, 1,  8'h80, 2,   0);
    applyStimulus("thr4_cpu",    1,   1,   0,   8'h80, 8'h00, 8'h00, 1,  8'h00, 3,   0);
    applyStimulus("thr5",        1,   1,   0,   8'h80, 8'h00, 8'h00, 1,  8'h80, 0,   0);
    applyStimulus("thr6",        1,   1,   0,   8'h80, 8'h00, 8'h00, 1,  8'h80, 1,   0);
    // Nasty bypasses the throttle and the count saturates
    applyStimulus("nasty1",      1,   1,   0,   8'h80, 8'h00, 8'h80, 1,  8'h80, 2,   0);
    applyStimulus("nasty2",      1,   1,   0,   8'h80, 8'h00, 8'h80, 1,  8'h80, 3,   0);
    applyStimulus("nasty3",      1,   1,   0,   8'h80, 8'h00, 8'h80, 1,  8'h80, 3,   0);
    applyStimulus("nasty4",      1,   1,   0,   8'h80, 8'h00, 8'h80, 1,  8'h80, 3,   0);
    applyStimulus("cpu_idle1",   1,   1,   0,   8'h80, 8'h00, 8'h00, 0,  8'h00, 3,   0);
    applyStimulus("cpu_idle2",   1,   1,   0,   8'h80, 8'h00, 8'h00, 0,  8'h80, 0,   0);
    // Burst lock on channel 6 with NOLOCK pre-emption by channel 0
    applyStimulus("lk1",         1,   1,   1,   8'h40, 8'h40, 8'h00, 0,  8'h40, 0,   0);
    applyStimulus("lk2",         1,   1,   1,   8'h44, 8'h40, 8'h00, 0,  8'h40, 0,   1);
    applyStimulus("lk3_pre",     1,   1,   1,   8'h45, 8'h40, 8'h00, 0,  8'h01, 0,   1);
    applyStimulus("lk4",         1,   1,   1,   8'h44, 8'h40, 8'h00, 0,  8'h40, 0,   1);
    applyStimulus("lk5",         1,   1,   1,   8'h44, 8'h40, 8'h00, 0,  8'h40, 0,   1);
    applyStimulus("lk6_ch2",     1,   1,   1,   8'h44, 8'h40, 8'h00, 0,  8'h04, 0,   0);
    // Re-lock barred directly after a LOCK_MAX release
    applyStimulus("lkB1",        1,   1,   1,   8'h40, 8'h40, 8'h00, 0,  8'h40, 0,   0);
    applyStimulus("lkB2",        1,   1,   1,   8'h40, 8'h40, 8'h00, 0,  8'h40, 0,   1);
    applyStimulus("lkB3",        1,   1,   1,   8'h40, 8'h40, 8'h00, 0,  8'h40, 0,   1);
    applyStimulus("lkB4",        1,   1,   1,   8'h40, 8'h40, 8'h00, 0,  8'h40, 0,   1);
    applyStimulus("lkB5_norel",  1,   1,   1,   8'h40, 8'h40, 8'h00, 0,  8'h40, 0,   0);
    applyStimulus("lkB6",        1,   1,   1,   8'h44, 8'h40, 8'h00, 0,  8'h04, 0,   0);
    applyStimulus("lkB7_relock", 1,   1,   1,   8'h40, 8'h40, 8'h00, 0,  8'h40, 0,   0);
    applyStimulus("lkB8_drop",   1,   1,   1,   8'h44, 8'h00, 8'h00, 0,  8'h40, 0,   1);
    applyStimulus("lkB9",        1,   1,   1,   8'h44, 8'h00, 8'h00, 0,  8'h04, 0,   0);
    // Asynchronous reset in the middle of a burst with a saturated counter
    applyStimulus("rb1",         1,   1,   1,   8'h40, 8'h40, 8'h00, 1,  8'h40, 0,   0);
    applyStimulus("rb2",         1,   1,   1,   8'h40, 8'h40, 8'h00, 1,  8'h40, 1,   1);
    applyStimulus("rb3",         1,   1,   1,   8'h40, 8'h40, 8'h00, 1,  8'h40, 2,   1);
    applyStimulus("rb4_pre",     1,   1,   1,   8'h41, 8'h40, 8'h00, 1,  8'h01, 3,   1);
    applyStimulus("rb5_reset",   0,   1,   1,   8'h41, 8'h40, 8'h00, 1,  8'h00, 0,   0);
    applyStimulus("rb6_rel",     1,   1,   1,   8'h00, 8'h00, 8'h00, 0,  8'h00, 0,   0);
    applyStimulus("rb7_prio",    1,   1,   1,   8'hFF, 8'h00, 8'h00, 0,  8'h01, 0,   0);
    applyStimulus("rb8_prio",    1,   1,   0,   8'hC0, 8'h00, 8'h00, 0,  8'h40, 0,   0);

    // Let the monitor drain the queue, within a bounded number of cycles
    for (int c = 0; c < 20 && expQ.size() > 0; c++) begin
      @(posedge clk);
    end
    if (expQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/agnus_dma_arbiter.md
# agnus_dma_arbiter

Parametrised N-channel chip-bus DMA arbiter for the Agnus bus slot. It generalises the fixed disk/refresh/audio/bitplane/sprite/copper/blitter priority chain into a table-driven fixed-priority arbiter with:
- per-channel slot qualification;
- a generic CPU-starvation throttle;
- burst locking with a bounded hold;
- a registered data-phase acknowledge.

It sits between the DMA engines and Gary, and drives the chip address, register address and bus-control strobes.

## Interface
Parameters:
- NCH, 8, number of DMA channels; index 0 has the highest priority.
- AW, 20, chip address width; the address covers bits [AW:1].
- RW, 8, register address width; the address covers bits [RW:1].
- ODD_ONLY, 8'h3F, per-channel bit: the channel may be granted only when cck=1.
- THROTTLE, 8'h80, per-channel bit: the channel is subject to the CPU-starvation throttle.
- NOLOCK, 8'h03, per-channel bit: the channel pre-empts a burst lock.
- STARVE_MAX, 3, starvation counter saturation value (2-bit counter, 1..3).
- LOCK_MAX, 4, maximum number of consecutive locked grants (1..15).

Ports:
- clk  in  1  master clock
- _reset  in  1  asynchronous, active-low reset
- clk7_en  in  1  bus-cycle enable; all state advances only when it is high
- cck  in  1  colour clock phase (1 = odd/chipset slot)
- req  in  NCH  per-channel DMA request
- ena  in  NCH  per-channel enable (DMACON-derived)
- hold  in  NCH  burst-lock request from the channel
- nasty  in  NCH  channel ignores the throttle (bltpri equivalent)
- we_in  in  NCH  per-channel write flag
- addr_in  in  NCH*AW  flattened channel chip addresses, channel i at [i*AW +: AW]
- reg_in  in  NCH*RW  flattened channel register addresses
- cpu_req  in  1  CPU wants a chip/custom cycle
- cpu_reg_address  in  RW  CPU register address (all-ones when idle)
- grant  out  NCH  one-hot combinational grant for this cycle
- ack_d  out  NCH  grant delayed by one clk7_en cycle (data phase)
- dbr  out  1  Agnus owns the bus
- dbwe  out  1  write cycle (we_in of the winner)
- cpu_custom  out  1  CPU owns the bus
- address_out  out  AW  winner address, 0 when no channel wins
- reg_address_out  out  RW  winner register address, cpu_reg_address when no channel wins
- starve_cnt  out  2  current starvation count
- lock_act  out  1  a burst lock is active

## Operation
- Eligibility of channel i: req[i] & ena[i] & (!ODD_ONLY[i] | cck) & !(THROTTLE[i] & !nasty[i] & starve_cnt==STARVE_MAX).
- Winner selection:
  - With no lock active, the winner is the lowest eligible index.
  - With a lock on owner k, the winner is the lowest eligible index j with NOLOCK[j]. If no such j exists, the winner is k when k is eligible. Otherwise there is no winner.
- No winner: grant=0, dbr=0, dbwe=0, cpu_custom=1, address_out=0, reg_address_out=cpu_reg_address.
- Winner exists: dbr=1, cpu_custom=0.
- Lock state (registers lock_act, lock_owner, lock_cnt):
  - Set when a winner w has hold[w]=1 and no lock is active: lock_owner=w, lock_cnt=1.
  - While the owner wins with hold=1: lock_cnt increments.
  - Released when the owner drops hold or req, or when lock_cnt reaches LOCK_MAX after a grant.
  - A cycle lost to a NOLOCK channel does not count and does not release the lock.
  - After a LOCK_MAX release, the owner cannot re-lock on the next cycle. It competes by plain priority.
- Starvation counter:
  - Cleared when cpu_req=0 or the CPU wins (no winner).
  - Incremented when cpu_req=1 and a channel wins.
  - Saturates at STARVE_MAX.
- ack_d is a register loaded with grant on every clk7_en.

## Timing
- While _reset is low: starve_cnt=0, lock_act=0, lock_owner=0, lock_cnt=0, ack_d=0. grant is forced to 0 and the outputs take their no-winner values.
- Deasserting _reset takes effect at the next clk7_en cycle.
- grant, dbr, dbwe, cpu_custom, address_out and reg_address_out are combinational: zero-cycle latency from the inputs and registered state.
- ack_d lags grant by exactly one clk7_en cycle.
- All register updates happen only on clk & clk7_en. Cycles with clk7_en low leave all state unchanged.
- A saturated throttle takes effect in the cycle after the increment that reaches STARVE_MAX. It clears in the cycle after the CPU wins.
- Simultaneous lock release and new lock request: release first, and the new winner may lock in the same cycle (subject to the LOCK_MAX re-lock rule).

## Test plan
- Priority: req=8'hFF, ena=8'hFF, cck=1 -> grant=8'h01; with cck=0 -> grant=8'h40 (channels 0-5 are odd-only).
- Throttle: only channel 7 requests, cpu_req=1, cck=0, over 3 enabled cycles -> starve_cnt=3. The 4th cycle gives grant=0 and cpu_custom=1. The 5th cycle gives grant=8'h80 with starve_cnt=0→1.
- Nasty: the throttle scenario with nasty[7]=1 -> channel 7 is granted every cycle and starve_cnt holds at 3.
- Burst lock: channel 6 hold=1, channel 2 also requesting, cck=1 -> channel 6 keeps the grant for 4 cycles, then channel 2 wins. A channel 0 request mid-lock pre-empts for 1 cycle with lock_act still 1.
- Data phase: grant sequence 01,00,40 -> ack_d sequence 00,01,00,40 (one cycle shifted).
- Reset mid-burst: assert _reset during a lock and a saturated counter -> lock_act=0, starve_cnt=0, ack_d=0 immediately (asynchronous). After release, plain priority resumes.
